// File: rtl/vga_timing_generator.sv
// Raster timing source: free-running pixel/line counters decoded into syncs, active flag and frame pulse.
// Optional macro VGA_TIMING_FRAME_COUNT_EN adds a 16-bit frameCount output.
module vga_timing_generator #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       screenEnd,
  output logic       active,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] x,
  output logic [8:0] y
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0] frameCount
`endif
);

  localparam int H_TOTAL = WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = HEIGHT + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS      = 10'(WIDTH);
  localparam logic [9:0] H_SYNC_BEG = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] H_SYNC_END = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_VIS      = 10'(HEIGHT);
  localparam logic [9:0] V_SYNC_BEG = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] V_SYNC_END = 10'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

  logic [9:0] h_count_q, h_count_d;
  logic [9:0] v_count_q, v_count_d;
  logic       h_wrap;

  always_comb begin
    h_wrap    = (h_count_q == H_LAST);
    h_count_d = h_wrap ? 10'd0 : h_count_q + 10'd1;
    v_count_d = v_count_q;
    if (h_wrap) begin
      v_count_d = (v_count_q == V_LAST) ? 10'd0 : v_count_q + 10'd1;
    end
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      h_count_q <= 10'd0;
      v_count_q <= 10'd0;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
    end
  end

  // Decodes use only the registered counters; active is gated by reset so the
  // zeroed counters do not look like a visible pixel while held in reset.
  always_comb begin
    active    = (h_count_q < H_VIS) && (v_count_q < V_VIS) && reset;
    hSync     = !((h_count_q >= H_SYNC_BEG) && (h_count_q < H_SYNC_END));
    vSync     = !((v_count_q >= V_SYNC_BEG) && (v_count_q < V_SYNC_END));
    screenEnd = (h_count_q == 10'd0) && (v_count_q == V_VIS) && reset;
    x         = h_count_q;
    y         = v_count_q[8:0];
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  always_comb begin
    frame_count_d = screenEnd ? frame_count_q + 16'd1 : frame_count_q;
  end

  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      frame_count_q <= 16'd0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frameCount = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: default 640x480 instance for line timing, a tiny-raster
// instance for whole-frame behaviour. Honours VGA_TIMING_FRAME_COUNT_EN.
module tb_vga_timing_generator;

  logic clk25 = 1'b0;
  logic reset = 1'b0;

  logic       d_se, d_act, d_hs, d_vs;
  logic [9:0] d_x;
  logic [8:0] d_y;
  logic       s_se, s_act, s_hs, s_vs;
  logic [9:0] s_x;
  logic [8:0] s_y;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d_hs_cnt = 0, d_hs_first = -1, d_act_cnt = 0;
  int s_act_cnt = 0, s_vs_cnt = 0, s_vs_first = -1, s_hs_cnt = 0, s_se_cnt = 0;

  typedef struct {
    int cyc;
    int x;
    int y;
    int act;
    int hs;
    int vs;
    int se;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  always #20 clk25 = ~clk25;

  vga_timing_generator dut (
    .clk25(clk25), .reset(reset), .screenEnd(d_se), .active(d_act),
    .hSync(d_hs), .vSync(d_vs), .x(d_x), .y(d_y)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frameCount(d_fc)
`endif
  );

  // Small raster: H_TOTAL 15 (hsync low at 10..12), V_TOTAL 13 (vsync low on lines 8..9), frame 195.
  vga_timing_generator #(
    .WIDTH(8), .HEIGHT(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_s (
    .clk25(clk25), .reset(reset), .screenEnd(s_se), .active(s_act),
    .hSync(s_hs), .vSync(s_vs), .x(s_x), .y(s_y)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frameCount(s_fc)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // cyc = number of rising edges since reset release, valid at each falling edge.
  always @(negedge clk25) begin
    if (reset) cyc++;
    else cyc = 0;
    if (cyc >= 800 && cyc < 1600) begin
      if (!d_hs) begin
        if (d_hs_cnt == 0) d_hs_first = int'(d_x);
        d_hs_cnt++;
      end
      if (d_act) d_act_cnt++;
    end
    if (cyc >= 1 && cyc <= 585) begin
      if (s_act) s_act_cnt++;
      if (!s_hs) s_hs_cnt++;
      if (!s_vs) begin
        if (s_vs_cnt == 0) s_vs_first = cyc;
        s_vs_cnt++;
      end
      if (s_se) begin
        chk("s_se_x", int'(s_x), 0);
        chk("s_se_y", int'(s_y), 6);
        chk("s_se_cyc", cyc, 90 + 195 * s_se_cnt);
        s_se_cnt++;
      end
`ifdef VGA_TIMING_FRAME_COUNT_EN
      case (cyc)
        90:  chk("s_fc_90", int'(s_fc), 0);
        91:  chk("s_fc_91", int'(s_fc), 1);
        286: chk("s_fc_286", int'(s_fc), 2);
        481: chk("s_fc_481", int'(s_fc), 3);
        default: ;
      endcase
`endif
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_d_x"}, int'(d_x), 0);
    chk({tag, "_d_y"}, int'(d_y), 0);
    chk({tag, "_d_act"}, int'(d_act), 0);
    chk({tag, "_d_hs"}, int'(d_hs), 1);
    chk({tag, "_d_vs"}, int'(d_vs), 1);
    chk({tag, "_d_se"}, int'(d_se), 0);
    chk({tag, "_s_x"}, int'(s_x), 0);
    chk({tag, "_s_y"}, int'(s_y), 0);
    chk({tag, "_s_act"}, int'(s_act), 0);
    chk({tag, "_s_hs"}, int'(s_hs), 1);
    chk({tag, "_s_vs"}, int'(s_vs), 1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    chk({tag, "_d_fc"}, int'(d_fc), 0);
    chk({tag, "_s_fc"}, int'(s_fc), 0);
`endif
  endtask

  task automatic advance_to(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      @(negedge clk25);
      #5;
      guard++;
    end
    chk("reach_cyc", cyc, target);
  endtask

  initial begin
    //          cyc    x    y  act hs vs se
    vecs[0]  = '{0,     0,   0, 1, 1, 1, 0};
    vecs[1]  = '{1,     1,   0, 1, 1, 1, 0};
    vecs[2]  = '{639, 639,   0, 1, 1, 1, 0};
    vecs[3]  = '{640, 640,   0, 0, 1, 1, 0};
    vecs[4]  = '{655, 655,   0, 0, 1, 1, 0};
    vecs[5]  = '{656, 656,   0, 0, 0, 1, 0};
    vecs[6]  = '{751, 751,   0, 0, 0, 1, 0};
    vecs[7]  = '{752, 752,   0, 0, 1, 1, 0};
    vecs[8]  = '{799, 799,   0, 0, 1, 1, 0};
    vecs[9]  = '{800,   0,   1, 1, 1, 1, 0};
    vecs[10] = '{1456, 656,  1, 0, 0, 1, 0};
    vecs[11] = '{1600,  0,   2, 1, 1, 1, 0};

    repeat (5) @(posedge clk25);
    @(negedge clk25);
    #5;
    chk_reset_vals("rst");

    #5 reset = 1'b1;
    #1;
    for (int i = 0; i < NV; i++) begin
      advance_to(vecs[i].cyc);
      chk($sformatf("v%0d_x", i), int'(d_x), vecs[i].x);
      chk($sformatf("v%0d_y", i), int'(d_y), vecs[i].y);
      chk($sformatf("v%0d_act", i), int'(d_act), vecs[i].act);
      chk($sformatf("v%0d_hs", i), int'(d_hs), vecs[i].hs);
      chk($sformatf("v%0d_vs", i), int'(d_vs), vecs[i].vs);
      chk($sformatf("v%0d_se", i), int'(d_se), vecs[i].se);
    end

    // Line 1 of the default raster and three full frames of the small one.
    advance_to(1900);
    chk("d_hs_cnt", d_hs_cnt, 96);
    chk("d_hs_first", d_hs_first, 656);
    chk("d_act_cnt", d_act_cnt, 640);
    chk("s_act_cnt", s_act_cnt, 144);
    chk("s_hs_cnt", s_hs_cnt, 117);
    chk("s_vs_cnt", s_vs_cnt, 90);
    chk("s_vs_first", s_vs_first, 120);
    chk("s_se_cnt", s_se_cnt, 3);

    // Mid-frame: default at (300,2); small raster sits inside both sync pulses.
    chk("mid_d_x", int'(d_x), 300);
    chk("mid_d_y", int'(d_y), 2);
    chk("mid_s_hs", int'(s_hs), 0);
    chk("mid_s_vs", int'(s_vs), 0);
    #5 reset = 1'b0;
    #1;
    chk_reset_vals("async");

    @(negedge clk25);
    #5;
    chk_reset_vals("hold");
    #5 reset = 1'b1;
    #1;
    chk("restart_d_x", int'(d_x), 0);
    chk("restart_d_y", int'(d_y), 0);
    chk("restart_d_act", int'(d_act), 1);
    chk("restart_s_x", int'(s_x), 0);
    @(negedge clk25);
    #5;
    chk("restart_d_x1", int'(d_x), 1);
    chk("restart_s_x1", int'(s_x), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
